// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core (m0)
// and the loader/debug port (m1), with a sequencer that zero-fills the memory.
module dm_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_wd,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rd
);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t            state, state_nxt;
  logic              last, last_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              done_nxt;

  // last == 1 means m1 was granted most recently, so m0 wins the next tie
  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    clr_busy   = 1'b0;
    dm_we      = 1'b0;
    dm_address = '0;
    dm_wd      = '0;
    case (state)
      ARB: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end else if (m0_req && (!m1_req || last)) begin
          m0_gnt     = 1'b1;
          dm_we      = m0_we;
          dm_address = m0_addr;
          dm_wd      = m0_wdata;
          last_nxt   = 1'b0;
        end else if (m1_req) begin
          m1_gnt     = 1'b1;
          dm_we      = m1_we;
          dm_address = m1_addr;
          dm_wd      = m1_wdata;
          last_nxt   = 1'b1;
        end
      end
      CLEAR: begin
        clr_busy   = 1'b1;
        dm_we      = 1'b1;
        dm_address = cnt;
        cnt_nxt    = cnt + ADDR_W'(1);
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt = ARB;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB;
      last      <= 1'b1;
      cnt       <= '0;
      clr_done  <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      clr_done  <= done_nxt;
      m0_rvalid <= m0_gnt && !m0_we;
      m1_rvalid <= m1_gnt && !m1_we;
      // read data is captured at the edge that ends the grant cycle
      if (m0_gnt && !m0_we)
        m0_rdata <= dm_rd;
      if (m1_gnt && !m1_we)
        m1_rdata <= dm_rd;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter with a behavioural 32x32 data memory.
`timescale 1ns/1ps
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [4:0]  m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [4:0]  m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        clr_start = 1'b0;
  logic        clr_busy, clr_done;
  logic [4:0]  dm_address;
  logic [31:0] dm_wd, dm_rd;
  logic        dm_we;

  logic [31:0] mem [32];

  int checks = 0;
  int failures = 0;
  int done_cnt;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (dm_we) mem[dm_address] <= dm_wd;
  assign dm_rd = mem[dm_address];

  dm_arbiter #(.ADDR_W(5), .DATA_W(32), .DEPTH(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .dm_address(dm_address), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
  );

  typedef struct {
    logic        m0_req, m0_we;
    logic [4:0]  m0_addr;
    logic [31:0] m0_wdata;
    logic        m1_req, m1_we;
    logic [4:0]  m1_addr;
    logic [31:0] m1_wdata;
    logic        e_g0, e_g1, e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_wd;
    logic        e_rv0, e_rv1;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int m, input logic we, input logic [4:0] a, input logic [31:0] d);
    if (m == 0) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic drop_req();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_write(input int m, input logic [4:0] a, input logic [31:0] d);
    set_req(m, 1'b1, a, d);
    #1;
    chk($sformatf("wr m%0d gnt", m), 32'((m == 0) ? m0_gnt : m1_gnt), 32'd1);
    @(posedge clk); #1;
    chk($sformatf("wr m%0d no rvalid", m), 32'((m == 0) ? m0_rvalid : m1_rvalid), 32'd0);
    drop_req();
  endtask

  task automatic do_read(input int m, input logic [4:0] a, input logic [31:0] exp);
    set_req(m, 1'b0, a, 32'd0);
    #1;
    chk($sformatf("rd m%0d a%0d gnt", m, a), 32'((m == 0) ? m0_gnt : m1_gnt), 32'd1);
    @(posedge clk); #1;
    chk($sformatf("rd m%0d a%0d rvalid", m, a), 32'((m == 0) ? m0_rvalid : m1_rvalid), 32'd1);
    chk($sformatf("rd m%0d a%0d rdata", m, a), (m == 0) ? m0_rdata : m1_rdata, exp);
    drop_req();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{1'b1,1'b1,5'd3,32'hDEADBEEF, 1'b0,1'b0,5'd0,32'h0, 1'b1,1'b0,1'b1,5'd3,32'hDEADBEEF, 1'b0,1'b0, 32'h0,32'h0};
    vt[1]  = '{1'b1,1'b0,5'd3,32'h0, 1'b0,1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0,5'd3,32'h0, 1'b1,1'b0, 32'hDEADBEEF,32'h0};
    vt[2]  = '{1'b0,1'b0,5'd0,32'h0, 1'b0,1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0,5'd0,32'h0, 1'b0,1'b0, 32'hDEADBEEF,32'h0};
    vt[3]  = '{1'b1,1'b1,5'd1,32'h11111111, 1'b0,1'b0,5'd0,32'h0, 1'b1,1'b0,1'b1,5'd1,32'h11111111, 1'b0,1'b0, 32'hDEADBEEF,32'h0};
    vt[4]  = '{1'b0,1'b0,5'd0,32'h0, 1'b1,1'b1,5'd2,32'h22222222, 1'b0,1'b1,1'b1,5'd2,32'h22222222, 1'b0,1'b0, 32'hDEADBEEF,32'h0};
    vt[5]  = '{1'b1,1'b0,5'd1,32'h0, 1'b1,1'b0,5'd2,32'h0, 1'b1,1'b0,1'b0,5'd1,32'h0, 1'b1,1'b0, 32'h11111111,32'h0};
    vt[6]  = '{1'b1,1'b0,5'd1,32'h0, 1'b1,1'b0,5'd2,32'h0, 1'b0,1'b1,1'b0,5'd2,32'h0, 1'b0,1'b1, 32'h11111111,32'h22222222};
    vt[7]  = '{1'b1,1'b0,5'd1,32'h0, 1'b1,1'b0,5'd2,32'h0, 1'b1,1'b0,1'b0,5'd1,32'h0, 1'b1,1'b0, 32'h11111111,32'h22222222};
    vt[8]  = '{1'b1,1'b0,5'd1,32'h0, 1'b1,1'b0,5'd2,32'h0, 1'b0,1'b1,1'b0,5'd2,32'h0, 1'b0,1'b1, 32'h11111111,32'h22222222};
    vt[9]  = '{1'b0,1'b0,5'd0,32'h0, 1'b1,1'b0,5'd3,32'h0, 1'b0,1'b1,1'b0,5'd3,32'h0, 1'b0,1'b1, 32'h11111111,32'hDEADBEEF};
    vt[10] = '{1'b0,1'b0,5'd0,32'h0, 1'b1,1'b0,5'd2,32'h0, 1'b0,1'b1,1'b0,5'd2,32'h0, 1'b0,1'b1, 32'h11111111,32'h22222222};
    vt[11] = '{1'b0,1'b0,5'd0,32'h0, 1'b1,1'b0,5'd1,32'h0, 1'b0,1'b1,1'b0,5'd1,32'h0, 1'b0,1'b1, 32'h11111111,32'h11111111};
    vt[12] = '{1'b1,1'b0,5'd3,32'h0, 1'b1,1'b0,5'd3,32'h0, 1'b1,1'b0,1'b0,5'd3,32'h0, 1'b1,1'b0, 32'hDEADBEEF,32'h11111111};
    vt[13] = '{1'b0,1'b0,5'd0,32'h0, 1'b0,1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0,5'd0,32'h0, 1'b0,1'b0, 32'hDEADBEEF,32'h11111111};

    #12;
    chk("rst m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst dm_we", 32'(dm_we), 32'd0);
    chk("rst clr_busy", 32'(clr_busy), 32'd0);
    chk("rst clr_done", 32'(clr_done), 32'd0);
    chk("rst m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst m0_rdata", m0_rdata, 32'd0);
    chk("rst m1_rdata", m1_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      m0_req = vt[i].m0_req; m0_we = vt[i].m0_we; m0_addr = vt[i].m0_addr; m0_wdata = vt[i].m0_wdata;
      m1_req = vt[i].m1_req; m1_we = vt[i].m1_we; m1_addr = vt[i].m1_addr; m1_wdata = vt[i].m1_wdata;
      #1;
      chk($sformatf("v%0d m0_gnt", i), 32'(m0_gnt), 32'(vt[i].e_g0));
      chk($sformatf("v%0d m1_gnt", i), 32'(m1_gnt), 32'(vt[i].e_g1));
      chk($sformatf("v%0d dm_we", i), 32'(dm_we), 32'(vt[i].e_we));
      chk($sformatf("v%0d dm_address", i), 32'(dm_address), 32'(vt[i].e_addr));
      chk($sformatf("v%0d dm_wd", i), dm_wd, vt[i].e_wd);
      @(posedge clk); #1;
      chk($sformatf("v%0d m0_rvalid", i), 32'(m0_rvalid), 32'(vt[i].e_rv0));
      chk($sformatf("v%0d m1_rvalid", i), 32'(m1_rvalid), 32'(vt[i].e_rv1));
      chk($sformatf("v%0d m0_rdata", i), m0_rdata, vt[i].e_rd0);
      chk($sformatf("v%0d m1_rdata", i), m1_rdata, vt[i].e_rd1);
    end
    drop_req();

    // full clear with m0 pending and a second clr_start mid-clear
    do_write(0, 5'd0, 32'hA5A5A5A5);
    do_write(0, 5'd17, 32'h17171717);
    do_write(1, 5'd31, 32'h31313131);
    set_req(0, 1'b0, 5'd0, 32'd0);
    clr_start = 1'b1;
    #1;
    chk("clr start no gnt", 32'(m0_gnt), 32'd0);
    chk("clr start dm_we", 32'(dm_we), 32'd0);
    @(posedge clk); #1;
    done_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      clr_start = (i == 10);
      #1;
      chk($sformatf("clr%0d busy", i), 32'(clr_busy), 32'd1);
      chk($sformatf("clr%0d dm_we", i), 32'(dm_we), 32'd1);
      chk($sformatf("clr%0d dm_address", i), 32'(dm_address), i);
      chk($sformatf("clr%0d dm_wd", i), dm_wd, 32'd0);
      chk($sformatf("clr%0d m0_gnt", i), 32'(m0_gnt), 32'd0);
      if (clr_done) done_cnt++;
      @(posedge clk); #1;
    end
    clr_start = 1'b0;
    #1;
    chk("clr done pulse", 32'(clr_done), 32'd1);
    chk("clr done busy", 32'(clr_busy), 32'd0);
    chk("clr done m0_gnt", 32'(m0_gnt), 32'd1);
    chk("clr no early done", done_cnt, 32'd0);
    @(posedge clk); #1;
    chk("clr done one cycle", 32'(clr_done), 32'd0);
    chk("post clr rvalid", 32'(m0_rvalid), 32'd1);
    chk("post clr a0", m0_rdata, 32'd0);
    drop_req();
    do_read(0, 5'd17, 32'd0);
    do_read(1, 5'd31, 32'd0);

    // reset asserted mid-clear at cnt = 10
    do_write(1, 5'd20, 32'h20202020);
    do_write(0, 5'd5, 32'h55555555);
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("abort cnt", 32'(dm_address), 32'd10);
    chk("abort busy before", 32'(clr_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort busy", 32'(clr_busy), 32'd0);
    chk("abort dm_we", 32'(dm_we), 32'd0);
    chk("abort done", 32'(clr_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (clr_done) done_cnt++;
    end
    chk("abort no done", done_cnt, 32'd0);
    chk("abort idle busy", 32'(clr_busy), 32'd0);
    do_read(1, 5'd20, 32'h20202020);
    do_read(0, 5'd5, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
